// File: rtl/ex_result_skid.sv
// ex_result_skid
// Result-side buffer of the execute stage. A two-register skid buffer holds up
// to two ALU results (main register drives the outputs, skid register catches
// the entry accepted while main is stalled), so in_ready is always a flop
// output. Optionally keeps the condition-code register {C, N, Z}.
//
// Build option: define EX_RESULT_CCR_EN to build the CCR flops, the flag logic
// and the ccr port. Without it in_op1/in_op2/in_mode are accepted but ignored
// and the handshake behaves identically.
module ex_result_skid #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_op2,
  input  logic [1:0]        in_mode,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_regwrite,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_regwrite
`ifdef EX_RESULT_CCR_EN
  ,
  output logic [2:0]        ccr
`endif
);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_NOT = 2'b01;

  // Buffer state: main entry (visible downstream) and skid entry
  logic              main_valid_reg, main_valid_next;
  logic [DATA_W-1:0] main_result_reg, main_result_next;
  logic [RA_W-1:0]   main_rd_reg, main_rd_next;
  logic              main_regwrite_reg, main_regwrite_next;

  logic              skid_valid_reg, skid_valid_next;
  logic [DATA_W-1:0] skid_result_reg, skid_result_next;
  logic [RA_W-1:0]   skid_rd_reg, skid_rd_next;
  logic              skid_regwrite_reg, skid_regwrite_next;

  logic accept;
  logic pop;

  // in_ready comes straight from the skid valid flop, never from downstream
  assign in_ready = ~skid_valid_reg;
  assign accept   = in_valid & in_ready;
  assign pop      = main_valid_reg & out_ready;

  assign out_valid    = main_valid_reg;
  assign out_result   = main_result_reg;
  assign out_rd       = main_rd_reg;
  assign out_regwrite = main_regwrite_reg & main_valid_reg;

  // Next-state of the two entries; flush drops both valid bits and the
  // entry being accepted in the same cycle
  always_comb begin
    main_valid_next    = main_valid_reg;
    main_result_next   = main_result_reg;
    main_rd_next       = main_rd_reg;
    main_regwrite_next = main_regwrite_reg;
    skid_valid_next    = skid_valid_reg;
    skid_result_next   = skid_result_reg;
    skid_rd_next       = skid_rd_reg;
    skid_regwrite_next = skid_regwrite_reg;

    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (pop && skid_valid_reg) begin
      // in_ready is low here, so no accept can coincide with this refill
      main_valid_next    = 1'b1;
      main_result_next   = skid_result_reg;
      main_rd_next       = skid_rd_reg;
      main_regwrite_next = skid_regwrite_reg;
      skid_valid_next    = 1'b0;
    end else if (accept && (!main_valid_reg || pop)) begin
      main_valid_next    = 1'b1;
      main_result_next   = in_result;
      main_rd_next       = in_rd;
      main_regwrite_next = in_regwrite;
    end else if (accept) begin
      // main is held: park the entry in skid, in_ready drops next cycle
      skid_valid_next    = 1'b1;
      skid_result_next   = in_result;
      skid_rd_next       = in_rd;
      skid_regwrite_next = in_regwrite;
    end else if (pop) begin
      main_valid_next = 1'b0;
    end
  end

  // Entry registers; reset clears payloads too so outputs start at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_reg    <= 1'b0;
      main_result_reg   <= '0;
      main_rd_reg       <= '0;
      main_regwrite_reg <= 1'b0;
      skid_valid_reg    <= 1'b0;
      skid_result_reg   <= '0;
      skid_rd_reg       <= '0;
      skid_regwrite_reg <= 1'b0;
    end else begin
      main_valid_reg    <= main_valid_next;
      main_result_reg   <= main_result_next;
      main_rd_reg       <= main_rd_next;
      main_regwrite_reg <= main_regwrite_next;
      skid_valid_reg    <= skid_valid_next;
      skid_result_reg   <= skid_result_next;
      skid_rd_reg       <= skid_rd_next;
      skid_regwrite_reg <= skid_regwrite_next;
    end
  end

`ifdef EX_RESULT_CCR_EN
  logic [DATA_W:0] sum_full;
  logic            res_zero;
  logic            res_neg;
  logic [2:0]      ccr_reg, ccr_next;

  // Carry is recomputed here because the ALU does not export it
  assign sum_full = {1'b0, in_op1} + {1'b0, in_op2};
  assign res_zero = (in_result == '0);
  assign res_neg  = in_result[DATA_W-1];

  // Flags follow acceptance order; flushed entries never touch them
  always_comb begin
    ccr_next = ccr_reg;
    if (accept && !flush) begin
      case (in_mode)
        MODE_ADD: ccr_next = {sum_full[DATA_W], res_neg, res_zero};
        MODE_NOT: ccr_next = {ccr_reg[2], res_neg, res_zero};
        default:  ccr_next = ccr_reg;
      endcase
    end
  end

  // Condition-code register {C, N, Z}
  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_reg <= 3'b000;
    end else begin
      ccr_reg <= ccr_next;
    end
  end

  assign ccr = ccr_reg;
`else
  // Operands and mode only feed the flag logic, which is not built here
  logic unused_ccr_inputs;
  assign unused_ccr_inputs = ^{in_op1, in_op2, in_mode, MODE_ADD, MODE_NOT};
`endif

endmodule

// File: tb/tb_ex_result_skid.sv
// Testbench for ex_result_skid: directed vectors, scoreboard queue filled by
// the driver on each accept, drained by an independent output monitor.
module tb_ex_result_skid;

  localparam int DATA_W = 16;
  localparam int RA_W   = 3;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RA_W-1:0]   rd;
    logic              regwrite;
  } entry_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] in_op1;
  logic [DATA_W-1:0] in_op2;
  logic [1:0]        in_mode;
  logic [RA_W-1:0]   in_rd;
  logic              in_regwrite;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [RA_W-1:0]   out_rd;
  logic              out_regwrite;
`ifdef EX_RESULT_CCR_EN
  logic [2:0]        ccr;
`endif

  int checks   = 0;
  int failures = 0;
  entry_t sb[$];

  ex_result_skid #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_op1       (in_op1),
    .in_op2       (in_op2),
    .in_mode      (in_mode),
    .in_rd        (in_rd),
    .in_regwrite  (in_regwrite),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_regwrite (out_regwrite)
`ifdef EX_RESULT_CCR_EN
    ,
    .ccr          (ccr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ccr(input string nm, input logic [2:0] exp);
`ifdef EX_RESULT_CCR_EN
    chk(nm, {29'd0, ccr}, {29'd0, exp});
`else
    if (exp === 3'bxxx) $display("unreachable %s", nm);
`endif
  endtask

  // Offer one entry; returns at posedge+1 of the cycle after acceptance
  task automatic send(input string tag, input logic [15:0] res, input logic [15:0] a,
                      input logic [15:0] b, input logic [1:0] mode,
                      input logic [2:0] rd, input logic rw);
    bit done = 0;
    in_valid = 1'b1; in_result = res; in_op1 = a; in_op2 = b;
    in_mode = mode; in_rd = rd; in_regwrite = rw;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{result: res, rd: rd, regwrite: rw});
        $display("push %s result=%04h rd=%0d rw=%0b", tag, res, rd, rw);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk({"accept_timeout_", tag}, 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Output monitor: compares every popped entry against the scoreboard head
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", {out_result, out_rd, out_regwrite}, 32'hFFFF_FFFF);
      end else begin
        entry_t e;
        e = sb.pop_front();
        $display("pop result=%04h rd=%0d rw=%0b", out_result, out_rd, out_regwrite);
        chk("pop_entry", {12'd0, out_result, out_rd, out_regwrite},
            {12'd0, e.result, e.rd, e.regwrite});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_result = '0; in_op1 = '0; in_op2 = '0; in_mode = 2'b11; in_rd = '0; in_regwrite = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_result", {16'd0, out_result}, 32'd0);
    chk("rst_out_rd", {29'd0, out_rd}, 32'd0);
    chk("rst_out_regwrite", {31'd0, out_regwrite}, 32'd0);
    chk_ccr("rst_ccr", 3'b000);

    // ADD 7FFF+0001 -> 8000: visible next cycle, C0 N1 Z0
    out_ready = 1'b1;
    send("add8000", 16'h8000, 16'h7FFF, 16'h0001, 2'b00, 3'd3, 1'b1);
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_out_result", {16'd0, out_result}, 32'h8000);
    chk("lat_out_rd", {29'd0, out_rd}, 32'd3);
    chk_ccr("ccr_add8000", 3'b010);
    idle(2);
    chk("drained_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drained_regwrite_gated", {31'd0, out_regwrite}, 32'd0);

    // ADD FFFF+0001 -> 0 then NOT -> 00FF, back to back
    send("add0000", 16'h0000, 16'hFFFF, 16'h0001, 2'b00, 3'd1, 1'b1);
    chk_ccr("ccr_add_zero", 3'b101);
    send("not00ff", 16'h00FF, 16'hFF00, 16'h0000, 2'b01, 3'd2, 1'b0);
    chk_ccr("ccr_not_c_held", 3'b100);
    chk("thru_out_valid", {31'd0, out_valid}, 32'd1);
    chk("thru_out_result", {16'd0, out_result}, 32'h00FF);
    idle(3);

    // Stall: A to main, B to skid, C held off until out_ready returns
    out_ready = 1'b0;
    send("A", 16'hAAAA, 16'h0, 16'h0, 2'b10, 3'd4, 1'b1);
    send("B", 16'hBBBB, 16'h0, 16'h0, 2'b10, 3'd5, 1'b0);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    fork
      send("C", 16'hCCCC, 16'h0, 16'h0, 2'b10, 3'd6, 1'b1);
      begin
        repeat (2) begin
          @(negedge clk);
          chk("stall_in_ready_hold", {31'd0, in_ready}, 32'd0);
          chk("stall_out_stable", {16'd0, out_result}, 32'hAAAA);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    idle(4);
    chk_ccr("ccr_after_pass", 3'b100);

    // Skid full, flush with in_valid high
    out_ready = 1'b0;
    send("D", 16'h0D0D, 16'h0, 16'h0, 2'b10, 3'd1, 1'b1);
    send("E", 16'h0E0E, 16'h0, 16'h0, 2'b10, 3'd2, 1'b1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_result = 16'h0000; in_op1 = 16'hFFFF; in_op2 = 16'h0001; in_mode = 2'b00;
    flush = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk_ccr("flush_ccr", 3'b100);

    // Flush coinciding with a real accept: entry dropped, flags untouched
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_acc_out_valid", {31'd0, out_valid}, 32'd0);
    chk_ccr("flush_acc_ccr", 3'b100);

    // Nonzero ADD, then PASS 0 and NOP: flags held, entries still retired
    out_ready = 1'b1;
    send("addF001", 16'hF001, 16'hF000, 16'h0001, 2'b00, 3'd7, 1'b1);
    chk_ccr("ccr_addF001", 3'b010);
    send("pass0", 16'h0000, 16'h0000, 16'h0000, 2'b10, 3'd5, 1'b1);
    send("nop", 16'h0000, 16'hFFFF, 16'h0001, 2'b11, 3'd6, 1'b0);
    chk_ccr("ccr_pass_nop_held", 3'b010);
    idle(3);

    // Reset with both entries valid and flush asserted
    out_ready = 1'b0;
    send("G", 16'h1111, 16'h0, 16'h0, 2'b10, 3'd1, 1'b1);
    send("H", 16'h2222, 16'h0, 16'h0, 2'b10, 3'd2, 1'b1);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst2_out_result", {16'd0, out_result}, 32'd0);
    chk("rst2_out_rd", {29'd0, out_rd}, 32'd0);
    chk("rst2_out_regwrite", {31'd0, out_regwrite}, 32'd0);
    chk_ccr("rst2_ccr", 3'b000);

    out_ready = 1'b1;
    idle(3);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
